// File: rtl/flash_byte_streamer_pkg.sv
// Shared definitions for the flash byte streamer: state encoding, SPI widths, byte select helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package flash_byte_streamer_pkg;

   localparam int SPI_ADDR_W = 24;
   localparam int SPI_WORD_W = 32;

   // Controller states, kept as plain constants so legacy tools can read the encoding.
   localparam logic [2:0] ST_BOOT       = 3'd0;
   localparam logic [2:0] ST_IDLE       = 3'd1;
   localparam logic [2:0] ST_ISSUE      = 3'd2;
   localparam logic [2:0] ST_WAIT       = 3'd3;
   localparam logic [2:0] ST_DRAIN_ONLY = 3'd4;
   localparam logic [2:0] ST_FLUSH      = 3'd5;

   typedef logic [SPI_ADDR_W-1:0] spi_addr_t;
   typedef logic [SPI_WORD_W-1:0] spi_word_t;

   // Byte idx of a flash word; idx 0 is the byte at the lowest flash address (MSB lane).
   function automatic logic [7:0] word_byte(input spi_word_t w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/flash_byte_streamer_if.sv
// Bundle of request, byte-stream and spi_master handshake signals around the streamer.
// Latency: n/a (wires only).
// Backpressure: out_ready/out_valid on the byte stream, req_valid/req_ready on requests.
// Modports: master = streamer view, slave = consumer/spi_master/environment view.
interface flash_byte_streamer_if #(
   parameter int LEN_W = 16
);
   import flash_byte_streamer_pkg::*;

   logic             req_valid;
   logic             req_ready;
   spi_addr_t        req_addr;
   logic [LEN_W-1:0] req_len;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;
   logic             done;
   logic             busy;
   logic             spi_addr_buffer_free;
   logic             spi_addr_en;
   spi_addr_t        spi_addr_data;
   logic             spi_rd_data_available;
   spi_word_t        spi_rd_data;
   logic             spi_rd_ack;

   modport master (
      input  req_valid, req_addr, req_len, abort, out_ready,
             spi_addr_buffer_free, spi_rd_data_available, spi_rd_data,
      output req_ready, out_valid, out_data, out_last, done, busy,
             spi_addr_en, spi_addr_data, spi_rd_ack
   );

   modport slave (
      output req_valid, req_addr, req_len, abort, out_ready,
             spi_addr_buffer_free, spi_rd_data_available, spi_rd_data,
      input  req_ready, out_valid, out_data, out_last, done, busy,
             spi_addr_en, spi_addr_data, spi_rd_ack
   );

endinterface

// File: rtl/flash_word_unpacker.sv
// One-word buffer that serialises a 32-bit flash word into bytes, lowest address first.
// Latency: load -> out_valid_o next cycle; one byte per cycle while out_ready_i is high.
// Backpressure: holds the word while out_ready_i is low; free_o says a load may land this cycle.
// Ports: clear_i drops the word, load_i/load_dat_i write it, last_i marks the final request
//        byte, pop_o flags an accepted byte, out_* is the byte stream.
module flash_word_unpacker
   import flash_byte_streamer_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear_i,
   input  logic       load_i,
   input  spi_word_t  load_dat_i,
   input  logic       last_i,
   input  logic       out_ready_i,
   output logic       out_valid_o,
   output logic [7:0] out_data_o,
   output logic       out_last_o,
   output logic       pop_o,
   output logic       free_o
);

   logic      full_q, full_d;
   spi_word_t word_q, word_d;
   logic [1:0] idx_q, idx_d;
   logic      empty_now;

   assign pop_o     = full_q & out_ready_i;
   // The word is finished after its fourth byte or after the last byte of the request;
   // any lanes beyond the request length are simply dropped.
   assign empty_now = pop_o & ((idx_q == 2'd3) | last_i);
   // A load may land in the same cycle the old word finishes, so the stream has no bubble.
   assign free_o    = ~full_q | empty_now;

   assign out_valid_o = full_q;
   assign out_data_o  = word_byte(word_q, idx_q);
   assign out_last_o  = full_q & last_i;

   always_comb begin
      full_d = full_q;
      word_d = word_q;
      idx_d  = idx_q;
      if (clear_i) begin
         full_d = 1'b0;
         idx_d  = 2'd0;
      end else if (load_i) begin
         full_d = 1'b1;
         word_d = load_dat_i;
         idx_d  = 2'd0;
      end else if (empty_now) begin
         full_d = 1'b0;
         idx_d  = 2'd0;
      end else if (pop_o) begin
         idx_d  = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_q <= 1'b0;
         word_q <= '0;
         idx_q  <= 2'd0;
      end else begin
         full_q <= full_d;
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/flash_byte_streamer.sv
// Turns (address, length) read requests into spi_master word reads and a byte stream.
// Latency: accept -> spi_addr_en >= 2 cycles; rd_data_available -> out_valid 1 cycle.
// Backpressure: a full word buffer holds off rd_ack, so at most one word waits in spi_master.
// Ports: clk, reset_n (async, active low); bus carries request, byte stream, done/busy/abort
//        and the spi_master addr_en/addr_data/rd_ack handshake.
module flash_byte_streamer
   import flash_byte_streamer_pkg::*;
#(
   parameter logic [31:0] STARTUP_CYCLES = 32'h1000000,
   parameter int          LEN_W          = 16
) (
   input logic                   clk,
   input logic                   reset_n,
   flash_byte_streamer_if.master bus
);

   logic [2:0]       state_q, state_d;
   logic [31:0]      boot_cnt_q, boot_cnt_d;
   spi_addr_t        cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
   logic [LEN_W-2:0] words_left_q, words_left_d;
   logic             done_q, done_d;
   logic             addr_en_q, addr_en_d;
   spi_addr_t        addr_data_q, addr_data_d;
   logic             rd_ack_q, rd_ack_d;

   logic             buf_free;
   logic             pop;
   logic             capture;
   logic             clear;
   logic [LEN_W-2:0] words_req;

   // ceil(req_len / 4)
   assign words_req = (LEN_W-1)'(bus.req_len[LEN_W-1:2]) + (LEN_W-1)'(|bus.req_len[1:0]);

   assign capture = (state_q == ST_WAIT) & bus.spi_rd_data_available & buf_free & ~bus.abort;
   assign clear   = bus.abort & ((state_q == ST_ISSUE) | (state_q == ST_WAIT) |
                                 (state_q == ST_DRAIN_ONLY));

   flash_word_unpacker u_unpacker (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear_i     (clear),
      .load_i      (capture),
      .load_dat_i  (bus.spi_rd_data),
      .last_i      (bytes_left_q == LEN_W'(1)),
      .out_ready_i (bus.out_ready),
      .out_valid_o (bus.out_valid),
      .out_data_o  (bus.out_data),
      .out_last_o  (bus.out_last),
      .pop_o       (pop),
      .free_o      (buf_free)
   );

   always_comb begin
      state_d      = state_q;
      boot_cnt_d   = boot_cnt_q;
      cur_addr_d   = cur_addr_q;
      bytes_left_d = bytes_left_q;
      words_left_d = words_left_q;
      done_d       = 1'b0;
      addr_en_d    = 1'b0;
      addr_data_d  = addr_data_q;
      rd_ack_d     = 1'b0;

      // Byte drain runs alongside the SPI side of the controller.
      if (pop) begin
         bytes_left_d = bytes_left_q - LEN_W'(1);
      end

      case (state_q)
         ST_BOOT: begin
            if (boot_cnt_q == STARTUP_CYCLES - 32'd1) begin
               state_d = ST_IDLE;
            end else begin
               boot_cnt_d = boot_cnt_q + 32'd1;
            end
         end
         ST_IDLE: begin
            if (bus.req_valid) begin
               cur_addr_d   = bus.req_addr;
               bytes_left_d = bus.req_len;
               words_left_d = words_req;
               if (bus.req_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (bus.abort) begin
               bytes_left_d = '0;
               done_d       = 1'b1;
               state_d      = ST_IDLE;
            end else if (bus.spi_addr_buffer_free) begin
               addr_en_d   = 1'b1;
               addr_data_d = cur_addr_q;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.abort) begin
               // A read is in flight; it must still be collected and acknowledged.
               bytes_left_d = '0;
               state_d      = ST_FLUSH;
            end else if (capture) begin
               rd_ack_d     = 1'b1;
               cur_addr_d   = cur_addr_q + SPI_ADDR_W'(4);
               words_left_d = words_left_q - (LEN_W-1)'(1);
               state_d      = (words_left_q != (LEN_W-1)'(1)) ? ST_ISSUE : ST_DRAIN_ONLY;
            end
         end
         ST_DRAIN_ONLY: begin
            if (bus.abort) begin
               bytes_left_d = '0;
               done_d       = 1'b1;
               state_d      = ST_IDLE;
            end else if (bytes_left_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (bus.spi_rd_data_available) begin
               rd_ack_d = 1'b1;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_BOOT;
         boot_cnt_q   <= '0;
         cur_addr_q   <= '0;
         bytes_left_q <= '0;
         words_left_q <= '0;
         done_q       <= 1'b0;
         addr_en_q    <= 1'b0;
         addr_data_q  <= '0;
         rd_ack_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         boot_cnt_q   <= boot_cnt_d;
         cur_addr_q   <= cur_addr_d;
         bytes_left_q <= bytes_left_d;
         words_left_q <= words_left_d;
         done_q       <= done_d;
         addr_en_q    <= addr_en_d;
         addr_data_q  <= addr_data_d;
         rd_ack_q     <= rd_ack_d;
      end
   end

   assign bus.req_ready     = (state_q == ST_IDLE);
   // busy spans acceptance through the done cycle.
   assign bus.busy          = ((state_q != ST_BOOT) & (state_q != ST_IDLE)) | done_q;
   assign bus.done          = done_q;
   assign bus.spi_addr_en   = addr_en_q;
   assign bus.spi_addr_data = addr_data_q;
   assign bus.spi_rd_ack    = rd_ack_q;

endmodule

// File: tb/tb_flash_byte_streamer.sv
// Randomised bench for flash_byte_streamer with a behavioural spi_master and flash image.
// Latency: spi_master model answers each read after 2-40 cycles.
// Backpressure: consumer ready is random, or held low for fixed stretches.
module tb_flash_byte_streamer;
   import flash_byte_streamer_pkg::*;

   localparam int          LEN_W   = 16;
   localparam logic [31:0] STARTUP = 32'd16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   flash_byte_streamer_if #(.LEN_W(LEN_W)) bus ();

   flash_byte_streamer #(.STARTUP_CYCLES(STARTUP), .LEN_W(LEN_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Flash image: bytes 00..04 at 100000h..100004h, scrambled elsewhere.
   function automatic logic [7:0] fb(input logic [23:0] a);
      logic [7:0] m1, m2;
      m1 = a[15:8] * 8'd37;
      m2 = (a[23:16] ^ 8'h10) * 8'd91;
      return a[7:0] ^ m1 ^ m2;
   endfunction

   // Reference model state
   logic [7:0]  exp_q[$];
   logic [23:0] exp_addr, cmd_addr;
   logic [31:0] rd_word;
   int cur_len, consumed, issued, acks, done_cnt, max_inflight, lat, hold_low;
   bit cmd_pending, avail, aborted, accepted_any;

   // spi_master model, consumer and scoreboard, all evaluated away from the active edge
   initial begin
      bus.spi_addr_buffer_free  = 1'b0;
      bus.spi_rd_data_available = 1'b0;
      bus.spi_rd_data           = '0;
      bus.out_ready             = 1'b0;
      cmd_pending = 0; avail = 0; aborted = 0; accepted_any = 0; hold_low = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            cmd_pending = 0;
            avail       = 0;
            bus.spi_addr_buffer_free  = 1'b0;
            bus.spi_rd_data_available = 1'b0;
            bus.out_ready             = 1'b0;
         end else begin
            if (bus.spi_addr_en) begin
               int inflight;
               chk("en_ack_excl", 32'(bus.spi_rd_ack), 0);
               chk("en_after_accept", 32'(accepted_any), 1);
               chk("en_single_cmd", 32'(cmd_pending), 0);
               chk("rd_addr", 32'(bus.spi_addr_data), 32'(exp_addr));
               cmd_addr    = bus.spi_addr_data;
               exp_addr    = exp_addr + 24'd4;
               issued++;
               cmd_pending = 1;
               lat         = int'($urandom_range(2, 40));
               inflight    = issued - consumed / 4;
               if (inflight > max_inflight) max_inflight = inflight;
               chk("inflight_le2", 32'(inflight <= 2), 1);
            end
            if (bus.spi_rd_ack) begin
               chk("ack_has_data", 32'(avail), 1);
               avail = 0;
               acks++;
               if (!aborted) begin
                  int room;
                  room = ((4 * acks < cur_len) ? 4 * acks : cur_len) - consumed;
                  chk("ack_buf_room", 32'(room <= 4), 1);
               end
            end
            if (cmd_pending && !avail) begin
               lat--;
               if (lat <= 0) begin
                  avail       = 1;
                  cmd_pending = 0;
                  rd_word     = {fb(cmd_addr), fb(cmd_addr + 24'd1),
                                 fb(cmd_addr + 24'd2), fb(cmd_addr + 24'd3)};
               end
            end
            bus.spi_addr_buffer_free  = !cmd_pending;
            bus.spi_rd_data_available = avail;
            bus.spi_rd_data           = rd_word;

            if (hold_low > 0) begin
               bus.out_ready = 1'b0;
               hold_low--;
            end else begin
               bus.out_ready = ($urandom_range(0, 99) < 70);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("byte_expected", 32'(exp_q.size()), 1);
               end else begin
                  logic [7:0] b;
                  b = exp_q.pop_front();
                  chk("out_data", 32'(bus.out_data), 32'(b));
                  chk("out_last", 32'(bus.out_last), 32'(exp_q.size() == 0));
                  consumed++;
               end
            end
            if (bus.done) done_cnt++;
         end
      end
   end

   task automatic start_req(input logic [23:0] addr, input int len, output int waited);
      bus.req_addr  = addr;
      bus.req_len   = LEN_W'(len);
      bus.req_valid = 1'b1;
      waited = 0;
      while (!bus.req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.req_ready) chk("req_ready_timeout", 0, 1);
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(fb(addr + 24'(i)));
      cur_len = len; consumed = 0; issued = 0; acks = 0; done_cnt = 0;
      max_inflight = 0; exp_addr = addr; aborted = 0; accepted_any = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (len == 0) chk("len0_done_next", 32'(bus.done), 1);
      else chk("busy_after_accept", 32'(bus.busy), 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", 32'(bus.done), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic end_checks(input int len);
      chk("bytes_pending", 32'(exp_q.size()), 0);
      chk("bytes_out", 32'(consumed), 32'(len));
      chk("reads_issued", 32'(issued), 32'((len + 3) / 4));
      chk("reads_acked", 32'(acks), 32'((len + 3) / 4));
      chk("done_pulses", 32'(done_cnt), 1);
      chk("busy_idle", 32'(bus.busy), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, en_seen, n, len;
      logic [23:0] a;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.abort     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_done_busy", 32'({bus.done, bus.busy, bus.out_last}), 0);
      chk("rst_spi_ctl", 32'({bus.spi_addr_en, bus.spi_rd_ack}), 0);
      chk("rst_spi_addr", 32'(bus.spi_addr_data), 0);
      reset_n = 1'b1;

      // Request pending from reset release: accepted only once the flash has powered up
      start_req(24'h100000, 5, w);
      chk("boot_ready_cycles", 32'(w), 32'(STARTUP));
      wait_done();
      end_checks(5);

      // Address wraps from the top of the 24-bit space
      start_req(24'hFFFFFE, 6, w);
      wait_done();
      end_checks(6);

      // Stalled consumer: one word buffered, one parked in spi_master, nothing lost
      hold_low = 50;
      start_req(24'h003000, 12, w);
      wait_done();
      end_checks(12);
      chk("max_inflight", 32'(max_inflight), 2);

      // Zero-length request: done only, no SPI traffic
      start_req(24'h123456, 0, w);
      repeat (3) @(negedge clk);
      chk("len0_reads", 32'(issued), 0);
      chk("len0_done_pulses", 32'(done_cnt), 1);

      // Abort with the second read outstanding and a full word buffer
      hold_low = 100000;
      start_req(24'h2000F0, 40, w);
      en_seen = 0;
      n = 0;
      while (en_seen < 2 && n < 500) begin
         @(negedge clk);
         n++;
         if (bus.spi_addr_en) en_seen++;
      end
      chk("abort_two_reads", 32'(en_seen), 2);
      chk("abort_buf_full", 32'(bus.out_valid), 1);
      aborted = 1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_valid_drop", 32'(bus.out_valid), 0);
      exp_q.delete();
      wait_done();
      chk("abort_acks", 32'(acks), 2);
      chk("abort_done_pulses", 32'(done_cnt), 1);
      chk("abort_no_bytes", 32'(consumed), 0);
      hold_low = 0;
      repeat (4) @(negedge clk);
      chk("abort_stream_quiet", 32'(bus.out_valid), 0);

      // Random requests, including near the top of the address space
      for (int k = 0; k < 8; k++) begin
         if (k % 3 == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 10));
         else a = 24'($urandom);
         len = int'($urandom_range(1, 24));
         start_req(a, len, w);
         wait_done();
         end_checks(len);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
